// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the hazard/forwarding controller: scoreboard entry, forward-select encoding, select width.
package pipeline_hazard_ctrl_pkg;

  localparam int HZ_ADDR_W   = 8;
  localparam int HZ_AVAIL_W  = 4;
  localparam int FWD_REGFILE = 0;

  // avail = stage count (from EX entry) after which the result can be forwarded
  typedef struct packed {
    logic                  valid;
    logic [HZ_ADDR_W-1:0]  waddr;
    logic [HZ_AVAIL_W-1:0] avail;
  } hz_entry_t;

  function automatic int sel_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ID-stage instruction info and pipeline control outputs between the cpu (master) and hazard controller (slave).
interface pipeline_hazard_ctrl_if
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3
);
  localparam int SEL_W = sel_w(DEPTH);

  logic                          pipe_en;
  logic                          id_valid;
  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr;
  logic [NUM_SRC-1:0]            id_src_used;
  logic                          id_wen;
  logic [REG_ADDR_W-1:0]         id_waddr;
  logic                          id_is_load;
  logic                          ex_br_taken;
  logic                          stall;
  logic                          ifid_en;
  logic                          ex_bubble;
  logic                          flush;
  logic [NUM_SRC*SEL_W-1:0]      fwd_sel;

  modport master (
    output pipe_en, id_valid, id_src_addr, id_src_used, id_wen, id_waddr, id_is_load, ex_br_taken,
    input  stall, ifid_en, ex_bubble, flush, fwd_sel
  );

  modport slave (
    input  pipe_en, id_valid, id_src_addr, id_src_used, id_wen, id_waddr, id_is_load, ex_br_taken,
    output stall, ifid_en, ex_bubble, flush, fwd_sel
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_src_match.sv
// One source operand against the scoreboard: youngest matching producer, its stage, and whether it is still unready.
module hazard_src_match
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_ENT    = 2,
  parameter int SEL_W      = 2
) (
  input  logic                  check,
  input  logic [REG_ADDR_W-1:0] src,
  input  hz_entry_t             ent [NUM_ENT],
  output logic                  hit,
  output logic [SEL_W-1:0]      sel,
  output logic                  not_ready
);

  // Scan oldest to youngest so the lowest stage index overrides.
  always_comb begin
    hit       = 1'b0;
    sel       = '0;
    not_ready = 1'b0;
    for (int s = NUM_ENT - 1; s >= 0; s--) begin
      if (check && ent[s].valid && (ent[s].waddr == HZ_ADDR_W'(src))) begin
        hit       = 1'b1;
        sel       = SEL_W'(s);
        not_ready = (int'(ent[s].avail) > s + 1);
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller: producer scoreboard, ID stall/bubble/flush, registered forward selects.
// HAZARD_PERF_CNT_EN adds saturating stall/flush cycle counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_LAT   = 1
) (
  input  logic                 clk,
  input  logic                 srst,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_flush_cnt,
`endif
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int SEL_W = sel_w(DEPTH);
  // The WB stage never forwards (write-through regfile), so only EX..DEPTH-2 are stored.
  localparam int NUM_ENT = DEPTH - 1;

  hz_entry_t                sb [NUM_ENT];
  hz_entry_t                new_ent;
  logic [NUM_SRC-1:0]       hit;
  logic [NUM_SRC-1:0]       not_ready;
  logic [SEL_W-1:0]         hit_s [NUM_SRC];
  logic [NUM_SRC*SEL_W-1:0] fwd_next;
  logic [NUM_SRC*SEL_W-1:0] fwd_q;
  logic                     stall_w;
  logic                     bubble_w;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hazard_src_match #(
      .REG_ADDR_W (REG_ADDR_W),
      .NUM_ENT    (NUM_ENT),
      .SEL_W      (SEL_W)
    ) u_match (
      .check     (hz.id_valid & hz.id_src_used[i]),
      .src       (hz.id_src_addr[i*REG_ADDR_W +: REG_ADDR_W]),
      .ent       (sb),
      .hit       (hit[i]),
      .sel       (hit_s[i]),
      .not_ready (not_ready[i])
    );
  end

  // A taken branch kills the dependent instruction, so it must not also stall.
  assign stall_w      = hz.pipe_en & ~hz.ex_br_taken & (|not_ready);
  assign bubble_w     = hz.pipe_en & (stall_w | hz.ex_br_taken);

  assign hz.stall     = stall_w;
  assign hz.ifid_en   = hz.pipe_en & ~stall_w;
  assign hz.ex_bubble = bubble_w;
  assign hz.flush     = hz.ex_br_taken;
  assign hz.fwd_sel   = fwd_q;

  always_comb begin
    new_ent       = '0;
    new_ent.valid = hz.id_valid & hz.id_wen & (hz.id_waddr != '0) & ~bubble_w;
    new_ent.waddr = HZ_ADDR_W'(hz.id_waddr);
    new_ent.avail = hz.id_is_load ? HZ_AVAIL_W'(1 + LOAD_LAT) : HZ_AVAIL_W'(1);
  end

  always_comb begin
    fwd_next = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      fwd_next[i*SEL_W +: SEL_W] = SEL_W'(FWD_REGFILE);
      if (!bubble_w && hit[i]) begin
        fwd_next[i*SEL_W +: SEL_W] = hit_s[i] + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int s = 0; s < NUM_ENT; s++) begin
        sb[s] <= '0;
      end
      fwd_q <= '0;
    end else if (hz.pipe_en) begin
      sb[0] <= new_ent;
      for (int s = 1; s < NUM_ENT; s++) begin
        sb[s] <= sb[s-1];
      end
      fwd_q <= fwd_next;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (srst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_w && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (hz.ex_br_taken && (perf_flush_cnt != 32'hFFFF_FFFF)) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench: default instance (DEPTH=3, LOAD_LAT=1) and deep instance (DEPTH=4, LOAD_LAT=2) share stimulus;
// each is checked against an age-based producer-history model. HAZARD_PERF_CNT_EN also checks counters.
module tb_pipeline_hazard_ctrl;

  localparam int AW = 5;
  localparam int NS = 2;
  localparam int SW = 2;

  typedef struct {
    int dest;
    int lat;
    int born;
  } prod_t;

  logic          clk = 1'b0;
  logic          srst;
  logic          pipe_en;
  logic          id_valid;
  logic [NS*AW-1:0] src_addr;
  logic [NS-1:0] used;
  logic          wen;
  logic [AW-1:0] waddr;
  logic          is_load;
  logic          br;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_ADDR_W(AW), .NUM_SRC(NS), .DEPTH(3)) ia ();
  pipeline_hazard_ctrl_if #(.REG_ADDR_W(AW), .NUM_SRC(NS), .DEPTH(4)) ib ();

  assign ia.pipe_en = pipe_en;   assign ib.pipe_en = pipe_en;
  assign ia.id_valid = id_valid; assign ib.id_valid = id_valid;
  assign ia.id_src_addr = src_addr; assign ib.id_src_addr = src_addr;
  assign ia.id_src_used = used;  assign ib.id_src_used = used;
  assign ia.id_wen = wen;        assign ib.id_wen = wen;
  assign ia.id_waddr = waddr;    assign ib.id_waddr = waddr;
  assign ia.id_is_load = is_load; assign ib.id_is_load = is_load;
  assign ia.ex_br_taken = br;    assign ib.ex_br_taken = br;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] pstall_a, pflush_a, pstall_b, pflush_b;
`endif

  pipeline_hazard_ctrl #(.REG_ADDR_W(AW), .NUM_SRC(NS), .DEPTH(3), .LOAD_LAT(1)) dut_a (
    .clk            (clk),
    .srst           (srst),
`ifdef HAZARD_PERF_CNT_EN
    .perf_stall_cnt (pstall_a),
    .perf_flush_cnt (pflush_a),
`endif
    .hz             (ia)
  );

  pipeline_hazard_ctrl #(.REG_ADDR_W(AW), .NUM_SRC(NS), .DEPTH(4), .LOAD_LAT(2)) dut_b (
    .clk            (clk),
    .srst           (srst),
`ifdef HAZARD_PERF_CNT_EN
    .perf_stall_cnt (pstall_b),
    .perf_flush_cnt (pflush_b),
`endif
    .hz             (ib)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  int     adv_cnt  = 0;
  prod_t  hist_a[$];
  prod_t  hist_b[$];
  int     exp_sel [2][NS];
  int     nsel    [2][NS];
  bit     e_stall [2];
  bit     e_bubble[2];
  logic   o_stall [2];
  logic   o_bubble[2];
  logic   o_flush [2];
  logic   o_ifid  [2];
  longint exp_pstall[2];
  longint exp_pflush[2];

  function automatic int depth_of(input int n);
    return (n == 0) ? 3 : 4;
  endfunction

  function automatic int ll_of(input int n);
    return (n == 0) ? 1 : 2;
  endfunction

  // Stage of the youngest producer of src still before WB, or -1; lat returns its forwarding latency.
  function automatic int youngest(input int n, input int src, output int lat);
    prod_t h[$];
    int    best;
    if (n == 0) h = hist_a; else h = hist_b;
    best = -1;
    lat  = 0;
    foreach (h[k]) begin
      int s;
      s = adv_cnt - 1 - h[k].born;
      if (h[k].dest == src && s <= depth_of(n) - 2 && (best < 0 || s < best)) begin
        best = s;
        lat  = h[k].lat;
      end
    end
    return best;
  endfunction

  function automatic int fwd_of(input int n, input int i);
    if (n == 0) return int'(ia.fwd_sel[i*SW +: SW]);
    return int'(ib.fwd_sel[i*SW +: SW]);
  endfunction

  task automatic chk(input string tag, input int n, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[inst%0d] observed=%0d expected=%0d", tag, n, obs, exp);
    end
  endtask

  task automatic set_id(input bit v, input int s0, input int s1, input bit [1:0] u,
                        input bit w, input int wa, input bit ld, input bit b);
    id_valid = v;
    src_addr = {AW'(s1), AW'(s0)};
    used     = u;
    wen      = w;
    waddr    = AW'(wa);
    is_load  = ld;
    br       = b;
  endtask

  task automatic idle();
    set_id(1'b0, 0, 0, 2'b00, 1'b0, 0, 1'b0, 1'b0);
  endtask

  // One cycle: predict and check combinational outputs, clock, then update model and check registered state.
  task automatic step();
    int  w;
    int  lat;
    bit  raw;
    #1;
    for (int n = 0; n < 2; n++) begin
      raw = 1'b0;
      for (int i = 0; i < NS; i++) begin
        nsel[n][i] = 0;
        if (id_valid && used[i]) begin
          w = youngest(n, int'(src_addr[i*AW +: AW]), lat);
          if (w >= 0) begin
            nsel[n][i] = w + 1;
            if (w + 1 < lat) raw = 1'b1;
          end
        end
      end
      e_stall[n]  = pipe_en && !br && raw;
      e_bubble[n] = pipe_en && (e_stall[n] || br);
      if (e_bubble[n]) begin
        for (int i = 0; i < NS; i++) nsel[n][i] = 0;
      end
      o_stall[n]  = (n == 0) ? ia.stall     : ib.stall;
      o_bubble[n] = (n == 0) ? ia.ex_bubble : ib.ex_bubble;
      o_flush[n]  = (n == 0) ? ia.flush     : ib.flush;
      o_ifid[n]   = (n == 0) ? ia.ifid_en   : ib.ifid_en;
      if (!srst) begin
        chk("stall",     n, 64'(o_stall[n]),  64'(e_stall[n]));
        chk("ex_bubble", n, 64'(o_bubble[n]), 64'(e_bubble[n]));
        chk("flush",     n, 64'(o_flush[n]),  64'(br));
        chk("ifid_en",   n, 64'(o_ifid[n]),   64'(pipe_en && !e_stall[n]));
      end
    end
    @(posedge clk);
    #1;
    if (srst) begin
      hist_a.delete();
      hist_b.delete();
      for (int n = 0; n < 2; n++) begin
        for (int i = 0; i < NS; i++) exp_sel[n][i] = 0;
        exp_pstall[n] = 0;
        exp_pflush[n] = 0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (e_stall[n] && exp_pstall[n] != 64'hFFFF_FFFF) exp_pstall[n]++;
        if (br && exp_pflush[n] != 64'hFFFF_FFFF) exp_pflush[n]++;
      end
      if (pipe_en) begin
        for (int n = 0; n < 2; n++) begin
          if (!e_bubble[n] && id_valid && wen && waddr != '0) begin
            prod_t p;
            p.dest = int'(waddr);
            p.lat  = is_load ? 1 + ll_of(n) : 1;
            p.born = adv_cnt;
            if (n == 0) hist_a.push_back(p); else hist_b.push_back(p);
          end
          for (int i = 0; i < NS; i++) exp_sel[n][i] = nsel[n][i];
        end
        adv_cnt++;
      end
    end
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < NS; i++) chk("fwd_sel", n, 64'(fwd_of(n, i)), 64'(exp_sel[n][i]));
    end
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall", 0, 64'(pstall_a), 64'(exp_pstall[0]));
    chk("perf_flush", 0, 64'(pflush_a), 64'(exp_pflush[0]));
    chk("perf_stall", 1, 64'(pstall_b), 64'(exp_pstall[1]));
    chk("perf_flush", 1, 64'(pflush_b), 64'(exp_pflush[1]));
`endif
  endtask

  task automatic drain();
    idle();
    for (int k = 0; k < 3; k++) step();
  endtask

  initial begin
    srst    = 1'b1;
    pipe_en = 1'b1;
    idle();
    step();
    srst = 1'b0;
    step();
    chk("rst_stall", 0, 64'(o_stall[0]), 64'd0);
    chk("rst_fwd",   0, 64'(ia.fwd_sel), 64'd0);

    // ALU producer r3 then consumer of r3 on operand 0
    set_id(1'b1, 0, 0, 2'b00, 1'b1, 3, 1'b0, 1'b0); step();
    set_id(1'b1, 3, 0, 2'b01, 1'b0, 0, 1'b0, 1'b0); step();
    chk("t1_stall", 0, 64'(o_stall[0]), 64'd0);
    chk("t1_fwd0",  0, 64'(fwd_of(0, 0)), 64'd1);
    drain();

    // load r4 then consumer on operand 1
    set_id(1'b1, 0, 0, 2'b00, 1'b1, 4, 1'b1, 1'b0); step();
    set_id(1'b1, 0, 4, 2'b10, 1'b0, 0, 1'b0, 1'b0); step();
    chk("t2_stall",  0, 64'(o_stall[0]),  64'd1);
    chk("t2_bubble", 0, 64'(o_bubble[0]), 64'd1);
    step();
    chk("t2_stall2", 0, 64'(o_stall[0]),  64'd0);
    chk("t2_fwd1",   0, 64'(fwd_of(0, 1)), 64'd2);
    chk("t3_stall2", 1, 64'(o_stall[1]),  64'd1);
    step();
    chk("t3_stall3", 1, 64'(o_stall[1]),  64'd0);
    chk("t3_fwd1",   1, 64'(fwd_of(1, 1)), 64'd3);
    drain();

    // producer to r0 never hazards; two producers of r5 -> youngest wins
    set_id(1'b1, 0, 0, 2'b00, 1'b1, 0, 1'b1, 1'b0); step();
    set_id(1'b1, 0, 0, 2'b01, 1'b0, 0, 1'b0, 1'b0); step();
    chk("t4_r0_stall", 0, 64'(o_stall[0]),  64'd0);
    chk("t4_r0_fwd",   0, 64'(fwd_of(0, 0)), 64'd0);
    set_id(1'b1, 0, 0, 2'b00, 1'b1, 5, 1'b0, 1'b0); step();
    step();
    set_id(1'b1, 5, 0, 2'b01, 1'b0, 0, 1'b0, 1'b0); step();
    chk("t4_r5_fwd", 0, 64'(fwd_of(0, 0)), 64'd1);
    drain();

    // load-use coinciding with a taken branch
    set_id(1'b1, 0, 0, 2'b00, 1'b1, 6, 1'b1, 1'b0); step();
    set_id(1'b1, 6, 0, 2'b01, 1'b0, 0, 1'b0, 1'b1); step();
    chk("t5_flush",  0, 64'(o_flush[0]),  64'd1);
    chk("t5_stall",  0, 64'(o_stall[0]),  64'd0);
    chk("t5_bubble", 0, 64'(o_bubble[0]), 64'd1);
    chk("t5_fwd",    0, 64'(fwd_of(0, 0)), 64'd0);
    drain();

    // pipe_en low holds everything and suppresses stall
    set_id(1'b1, 0, 0, 2'b00, 1'b1, 10, 1'b1, 1'b0); step();
    pipe_en = 1'b0;
    set_id(1'b1, 10, 0, 2'b01, 1'b0, 0, 1'b0, 1'b0); step();
    chk("hold_stall",  0, 64'(o_stall[0]),  64'd0);
    chk("hold_bubble", 0, 64'(o_bubble[0]), 64'd0);
    pipe_en = 1'b1;
    step();
    chk("resume_stall", 0, 64'(o_stall[0]), 64'd1);
    drain();

    // reset with three live producers
    set_id(1'b1, 0, 0, 2'b00, 1'b1, 7, 1'b0, 1'b0); step();
    set_id(1'b1, 0, 0, 2'b00, 1'b1, 8, 1'b1, 1'b0); step();
    set_id(1'b1, 0, 0, 2'b00, 1'b1, 9, 1'b1, 1'b0); step();
    srst = 1'b1;
    set_id(1'b1, 9, 8, 2'b11, 1'b0, 0, 1'b0, 1'b0); step();
    srst = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
    chk("t6_pstall0", 0, 64'(pstall_a), 64'd0);
    chk("t6_pflush0", 0, 64'(pflush_a), 64'd0);
`endif
    step();
    chk("t6_stall", 0, 64'(o_stall[0]), 64'd0);
    chk("t6_fwd",   0, 64'(ia.fwd_sel), 64'd0);
    set_id(1'b1, 0, 0, 2'b00, 1'b1, 11, 1'b1, 1'b0); step();
    set_id(1'b1, 11, 0, 2'b01, 1'b0, 0, 1'b0, 1'b0); step();
`ifdef HAZARD_PERF_CNT_EN
    chk("t6_pstall1", 0, 64'(pstall_a), 64'd1);
`endif
    drain();

    // randomized traffic over a small register set to provoke overlaps
    for (int k = 0; k < 600; k++) begin
      srst    = ($urandom_range(0, 49) == 0);
      pipe_en = ($urandom_range(0, 9) != 0);
      set_id(1'($urandom_range(0, 5) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0), $urandom_range(0, 3),
             1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0));
      step();
    end
    srst    = 1'b0;
    pipe_en = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
